// File: rtl/gmii_to_rgmii_tx_if.sv
// GMII-in / RGMII-SDR-out bundle for the transmit adapter, plus its statistics outputs.
// master = frame source side, slave = the adapter.
interface gmii_to_rgmii_tx_if #(
  parameter int CNT_W = 16
);
  logic             gmii_tx_en;
  logic [7:0]       gmii_txd;
  logic             gmii_tx_er;
  logic [3:0]       rgmii_d_h;
  logic [3:0]       rgmii_d_l;
  logic             rgmii_ctl_h;
  logic             rgmii_ctl_l;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic             oversize;

  modport master (
    output gmii_tx_en, gmii_txd, gmii_tx_er,
    input  rgmii_d_h, rgmii_d_l, rgmii_ctl_h, rgmii_ctl_l,
    input  frame_cnt, drop_cnt, oversize
  );

  modport slave (
    input  gmii_tx_en, gmii_txd, gmii_tx_er,
    output rgmii_d_h, rgmii_d_l, rgmii_ctl_h, rgmii_ctl_l,
    output frame_cnt, drop_cnt, oversize
  );
endinterface

// File: rtl/gmii_to_rgmii_tx.sv
// GMII->RGMII transmit adapter: 2-stage pipeline with IFG and max-length policing plus frame/drop counters.
// Optional macro RGMII_TX_ERR_EN: encode tx_er onto the falling-edge TX_CTL (ctl_l = en ^ er).
module gmii_to_rgmii_tx #(
  parameter int IFG_MIN   = 12,
  parameter int MAX_FRAME = 1526,
  parameter int CNT_W     = 16
) (
  input logic          gmii_tx_clk,
  input logic          reset,
  gmii_to_rgmii_tx_if.slave bus
);
  localparam int GAP_W = 8;
  localparam int BC_W  = $clog2(MAX_FRAME + 1);
  localparam logic [GAP_W-1:0] IFG_V = GAP_W'(IFG_MIN);
  localparam logic [BC_W-1:0]  MAX_V = BC_W'(MAX_FRAME);

  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_DROP} state_t;

  state_t           r_state, w_state_next;
  logic             r_en_s1, r_en_prev;
  logic [7:0]       r_txd_s1;
  logic [GAP_W-1:0] r_gap_cnt, w_gap_next;
  logic [BC_W-1:0]  r_byte_cnt, w_byte_next;
  logic [CNT_W-1:0] r_frame_cnt, r_drop_cnt;
  logic [3:0]       r_d_h, r_d_l;
  logic             r_ctl_h, r_ctl_l, r_oversize;
  logic             w_start, w_fwd, w_frame_inc, w_drop_inc, w_ovs, w_ctl_l;

  // en_s1/en_prev come out of reset as "busy" so a frame already on the wire
  // at reset release never produces a start edge.
  always_ff @(posedge gmii_tx_clk) begin
    if (reset) begin
      r_en_s1   <= 1'b1;
      r_en_prev <= 1'b1;
      r_txd_s1  <= 8'd0;
    end else begin
      r_en_s1   <= bus.gmii_tx_en;
      r_en_prev <= r_en_s1;
      r_txd_s1  <= bus.gmii_txd;
    end
  end

`ifdef RGMII_TX_ERR_EN
  logic r_er_s1;
  always_ff @(posedge gmii_tx_clk) begin
    if (reset) r_er_s1 <= 1'b0;
    else       r_er_s1 <= bus.gmii_tx_er;
  end
  assign w_ctl_l = w_fwd ? ~r_er_s1 : (r_state == S_IDLE && !r_en_s1 && r_er_s1);
`else
  assign w_ctl_l = w_fwd;
`endif

  assign w_start = !r_en_prev && r_en_s1;

  always_comb begin
    w_state_next = r_state;
    w_gap_next   = r_gap_cnt;
    w_byte_next  = r_byte_cnt;
    w_fwd        = 1'b0;
    w_frame_inc  = 1'b0;
    w_drop_inc   = 1'b0;
    w_ovs        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (r_gap_cnt >= IFG_V) begin
            w_state_next = S_FRAME;
            w_byte_next  = BC_W'(1);
            w_fwd        = 1'b1;
          end else begin
            w_state_next = S_DROP;
            w_drop_inc   = 1'b1;
          end
        end else if (!r_en_s1 && r_gap_cnt < IFG_V) begin
          w_gap_next = r_gap_cnt + 1'b1;
        end
      end
      S_FRAME: begin
        // The exit cycle already has en low, so it is the first gap cycle.
        if (!r_en_s1) begin
          w_state_next = S_IDLE;
          w_frame_inc  = 1'b1;
          w_gap_next   = GAP_W'(1);
        end else if (r_byte_cnt == MAX_V) begin
          w_state_next = S_DROP;
          w_ovs        = 1'b1;
          w_gap_next   = '0;
        end else begin
          w_fwd       = 1'b1;
          w_byte_next = r_byte_cnt + 1'b1;
        end
      end
      S_DROP: begin
        if (!r_en_s1) begin
          w_state_next = S_IDLE;
          w_gap_next   = GAP_W'(1);
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge gmii_tx_clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_gap_cnt   <= IFG_V;
      r_byte_cnt  <= '0;
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
      r_d_h       <= 4'd0;
      r_d_l       <= 4'd0;
      r_ctl_h     <= 1'b0;
      r_ctl_l     <= 1'b0;
      r_oversize  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_gap_cnt  <= w_gap_next;
      r_byte_cnt <= w_byte_next;
      if (w_frame_inc) r_frame_cnt <= r_frame_cnt + 1'b1;
      if (w_drop_inc && r_drop_cnt != {CNT_W{1'b1}}) r_drop_cnt <= r_drop_cnt + 1'b1;
      r_d_h      <= w_fwd ? r_txd_s1[3:0] : 4'd0;
      r_d_l      <= w_fwd ? r_txd_s1[7:4] : 4'd0;
      r_ctl_h    <= w_fwd;
      r_ctl_l    <= w_ctl_l;
      r_oversize <= w_ovs;
    end
  end

  assign bus.rgmii_d_h   = r_d_h;
  assign bus.rgmii_d_l   = r_d_l;
  assign bus.rgmii_ctl_h = r_ctl_h;
  assign bus.rgmii_ctl_l = r_ctl_l;
  assign bus.frame_cnt   = r_frame_cnt;
  assign bus.drop_cnt    = r_drop_cnt;
  assign bus.oversize    = r_oversize;
endmodule

// File: tb/tb_gmii_to_rgmii_tx.sv
// Directed bench for gmii_to_rgmii_tx: expected output bytes are queued at drive time and
// a monitor pops and compares them (value and arrival cycle) whenever TX_CTL rising is high.
module tb_gmii_to_rgmii_tx;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gmii_to_rgmii_tx_if #(.CNT_W(CNT_W)) bus ();

  gmii_to_rgmii_tx #(
    .IFG_MIN  (12),
    .MAX_FRAME(1526),
    .CNT_W    (CNT_W)
  ) u_dut (
    .gmii_tx_clk(clk),
    .reset      (reset),
    .bus        (bus)
  );

  typedef struct {
    logic [3:0] d_h;
    logic [3:0] d_l;
    logic       ctl_l;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec    = 0;
  int   n_err    = 0;
  int   n_ovs    = 0;
  int   idle_bad = 0;

  function automatic logic exp_ctl_l(input logic en, input logic er);
`ifdef RGMII_TX_ERR_EN
    return en ^ er;
`else
    return en | (er & 1'b0);
`endif
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // One input cycle; a forwarded byte is expected on the outputs two cycles later.
  task automatic step(input logic en, input logic [7:0] d, input logic er,
                      input logic rst, input logic fwd);
    exp_t e;
    @(posedge clk);
    #1;
    bus.gmii_tx_en = en;
    bus.gmii_txd   = d;
    bus.gmii_tx_er = er;
    reset          = rst;
    if (fwd) begin
      e.d_h   = d[3:0];
      e.d_l   = d[7:4];
      e.ctl_l = exp_ctl_l(en, er);
      e.cyc   = cyc + 2;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame(input int len, input int fwd_bytes, input int er_at, input int rst_at);
    for (int k = 0; k < len; k++)
      step(1'b1, 8'(k), k == er_at, k == rst_at, k < fwd_bytes);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.oversize === 1'b1) n_ovs++;
      if (bus.rgmii_ctl_h === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_byte: got d_h=%h d_l=%h at cycle %0d, expected no byte",
                   bus.rgmii_d_h, bus.rgmii_d_l, cyc);
        end else begin
          e = exp_q.pop_front();
          if (bus.rgmii_d_h !== e.d_h || bus.rgmii_d_l !== e.d_l ||
              bus.rgmii_ctl_l !== e.ctl_l || cyc != e.cyc) begin
            n_err++;
            $display("FAIL byte: got d_h=%h d_l=%h ctl_l=%b cycle %0d, expected d_h=%h d_l=%h ctl_l=%b cycle %0d",
                     bus.rgmii_d_h, bus.rgmii_d_l, bus.rgmii_ctl_l, cyc,
                     e.d_h, e.d_l, e.ctl_l, e.cyc);
          end
        end
      end else begin
        if ({bus.rgmii_d_h, bus.rgmii_d_l, bus.rgmii_ctl_l} !== 9'd0) idle_bad++;
        if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
          e = exp_q.pop_front();
          n_vec++;
          n_err++;
          $display("FAIL missing_byte: got idle at cycle %0d, expected d_h=%h d_l=%h at cycle %0d",
                   cyc, e.d_h, e.d_l, e.cyc);
        end
      end
    end
  endtask

  initial begin
    bus.gmii_tx_en = 1'b0;
    bus.gmii_txd   = 8'd0;
    bus.gmii_tx_er = 1'b0;
    reset          = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_d_h",      int'(bus.rgmii_d_h),   0);
    chk("rst_d_l",      int'(bus.rgmii_d_l),   0);
    chk("rst_ctl_h",    int'(bus.rgmii_ctl_h), 0);
    chk("rst_ctl_l",    int'(bus.rgmii_ctl_l), 0);
    chk("rst_frame",    int'(bus.frame_cnt),   0);
    chk("rst_drop",     int'(bus.drop_cnt),    0);
    chk("rst_oversize", int'(bus.oversize),    0);
    fork
      monitor();
    join_none

    // 64-byte frame immediately after reset
    idle(12);
    frame(64, 64, -1, -1);
    idle(12);
    chk("t1_frame", int'(bus.frame_cnt), 1);

    // gap 11 drops, gap 12 forwards
    frame(8, 8, -1, -1);
    idle(11);
    frame(8, 0, -1, -1);
    idle(12);
    chk("t2_drop",   int'(bus.drop_cnt),  1);
    chk("t2_frame",  int'(bus.frame_cnt), 2);
    frame(8, 8, -1, -1);
    idle(12);
    chk("t2_frame2", int'(bus.frame_cnt), 3);

    // truncation at 1526 bytes, then an exactly-maximal frame
    frame(2000, 1526, -1, -1);
    idle(12);
    chk("t3_oversize", n_ovs, 1);
    chk("t3_frame",    int'(bus.frame_cnt), 3);
    frame(1526, 1526, -1, -1);
    idle(12);
    chk("t3_oversize2", n_ovs, 1);
    chk("t3_frame2",    int'(bus.frame_cnt), 4);

    // tx_er on byte 10
    frame(16, 16, 10, -1);
    idle(3);
    chk("t5_frame", int'(bus.frame_cnt), 5);

    // short-gap frames saturate drop_cnt
    for (int i = 0; i < 16; i++) begin
      frame(4, 0, -1, -1);
      idle(3);
    end
    idle(9);
    chk("t6_drop_sat", int'(bus.drop_cnt),  15);
    chk("t6_frame",    int'(bus.frame_cnt), 5);

    // frame_cnt wraps
    for (int i = 0; i < 10; i++) begin
      frame(4, 4, -1, -1);
      idle(12);
    end
    chk("t6_frame_max", int'(bus.frame_cnt), 15);
    frame(4, 4, -1, -1);
    idle(12);
    chk("t6_frame_wrap", int'(bus.frame_cnt), 0);

    // reset at byte 30 of a 100-byte frame
    frame(100, 29, -1, 30);
    chk("t4_frame_rst", int'(bus.frame_cnt), 0);
    chk("t4_drop_rst",  int'(bus.drop_cnt),  0);
    idle(12);
    chk("t4_frame_ign", int'(bus.frame_cnt), 0);
    frame(20, 20, -1, -1);
    idle(12);
    chk("t4_frame_next", int'(bus.frame_cnt), 1);
    chk("t4_drop_next",  int'(bus.drop_cnt),  0);

    idle(4);
    chk("end_queue_empty", exp_q.size(), 0);
    chk("end_idle_clean",  idle_bad,     0);
    chk("end_oversize",    n_ovs,        1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
